// File: rtl/lc3x_muldiv_unit_pkg.sv
// Shared types and op-class helpers for the LC-3X iterative multiply/divide unit.
// Optional feature macro used by the unit: LC3X_MULDIV_EARLY_OUT_EN.
package lc3x_muldiv_types;

    typedef enum logic [2:0] {
        MDOP_MUL   = 3'b000,  // low half of product
        MDOP_MULHU = 3'b001,  // high half, unsigned
        MDOP_MULHS = 3'b010,  // high half, signed
        MDOP_RSVD  = 3'b011,  // reserved, behaves as MUL
        MDOP_DIVU  = 3'b100,
        MDOP_DIVS  = 3'b101,
        MDOP_REMU  = 3'b110,
        MDOP_REMS  = 3'b111
    } lc3x_mdop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } lc3x_mdstate_t;

    function automatic logic is_div(input lc3x_mdop_t op);
        logic [2:0] v;
        v = op;
        return v[2];
    endfunction

    function automatic logic is_signed(input lc3x_mdop_t op);
        return (op == MDOP_MULHS) || (op == MDOP_DIVS) || (op == MDOP_REMS);
    endfunction

    function automatic logic is_high(input lc3x_mdop_t op);
        return (op == MDOP_MULHU) || (op == MDOP_MULHS);
    endfunction

    function automatic logic is_rem(input lc3x_mdop_t op);
        return (op == MDOP_REMU) || (op == MDOP_REMS);
    endfunction

endpackage

// File: rtl/lc3x_muldiv_unit_if.sv
// Start/stall/done handshake and operand/result bus between EX and the mul/div unit.
interface lc3x_muldiv_unit_if #(
    parameter int WIDTH = 16
) ();
    logic                          start;
    logic                          kill;
    lc3x_muldiv_types::lc3x_mdop_t op;
    logic [WIDTH-1:0]              a;
    logic [WIDTH-1:0]              b;
    logic                          stall;
    logic                          done;
    logic [WIDTH-1:0]              result;
    logic                          div_by_zero;

    // EX stage side
    modport master (
        output start, kill, op, a, b,
        input  stall, done, result, div_by_zero
    );

    // Execution unit side
    modport slave (
        input  start, kill, op, a, b,
        output stall, done, result, div_by_zero
    );
endinterface

// File: rtl/lc3x_sign_adj.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of the final product/quotient/remainder.
module lc3x_sign_adj #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);
    // Most-negative input maps to itself, which reads correctly as an unsigned magnitude.
    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
endmodule

// File: rtl/lc3x_muldiv_unit.sv
// LC-3X iterative multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, start/stall/done handshake with kill.
// Optional macro LC3X_MULDIV_EARLY_OUT_EN: multiplies finish once the remaining
// multiplier magnitude is zero instead of always running WIDTH iterations.
module lc3x_muldiv_unit
    import lc3x_muldiv_types::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    lc3x_muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    lc3x_mdstate_t      r_state, w_state_next;
    lc3x_mdop_t         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_quo, r_rem, r_dvsr;
    logic               r_neg_q, r_neg_r;
    logic [WIDTH-1:0]   r_result;
    logic               r_dbz;

    // Operand magnitudes at accept
    logic               w_in_signed;
    logic [WIDTH-1:0]   w_opnd_raw [2];
    logic [WIDTH-1:0]   w_opnd_mag [2];
    logic               w_opnd_neg [2];

    assign w_in_signed   = is_signed(bus.op);
    assign w_opnd_raw[0] = bus.a;
    assign w_opnd_raw[1] = bus.b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            assign w_opnd_neg[gi] = w_in_signed & w_opnd_raw[gi][WIDTH-1];
            lc3x_sign_adj #(.WIDTH(WIDTH)) u_mag (
                .i_val (w_opnd_raw[gi]),
                .i_neg (w_opnd_neg[gi]),
                .o_val (w_opnd_mag[gi])
            );
        end
    endgenerate

    logic w_accept, w_b_zero, w_cnt_last, w_mul_fin, w_done;
    assign w_accept   = (r_state == ST_IDLE) && bus.start && !bus.kill;
    assign w_b_zero   = (bus.b == '0);
    assign w_cnt_last = (r_cnt == CNT_W'(1));

    // One iteration of shift-add multiply
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   w_mplier_step;
    assign w_acc_step    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_step = r_mplier >> 1;

    // One iteration of restoring divide: shift in next dividend bit, trial subtract
    logic [WIDTH:0]     w_rem_sh, w_diff;
    logic [WIDTH-1:0]   w_quo_step, w_rem_step;
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_dvsr};
    assign w_quo_step = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_rem_step = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];

`ifdef LC3X_MULDIV_EARLY_OUT_EN
    assign w_mul_fin = w_cnt_last || (w_mplier_step == '0);
`else
    assign w_mul_fin = w_cnt_last;
`endif

    // Sign restoration of the final values, fed from this cycle's iteration output
    logic [2*WIDTH-1:0] w_prod_adj;
    logic [WIDTH-1:0]   w_div_adj;
    lc3x_sign_adj #(.WIDTH(2*WIDTH)) u_adj_prod (
        .i_val (w_acc_step),
        .i_neg (r_neg_q),
        .o_val (w_prod_adj)
    );
    lc3x_sign_adj #(.WIDTH(WIDTH)) u_adj_div (
        .i_val (is_rem(r_op) ? w_rem_step : w_quo_step),
        .i_neg (is_rem(r_op) ? r_neg_r : r_neg_q),
        .o_val (w_div_adj)
    );

    // Next-state logic; kill overrides every transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start)
                         w_state_next = is_div(bus.op) ? (w_b_zero ? ST_DONE : ST_DIV) : ST_MUL;
            ST_MUL:  if (w_mul_fin)  w_state_next = ST_DONE;
            ST_DIV:  if (w_cnt_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (bus.kill) w_state_next = ST_IDLE;
    end

    // Result to capture on entry to DONE, selected by the path that got there
    logic [WIDTH-1:0] w_res_fin;
    logic             w_dbz_fin;
    always_comb begin
        w_res_fin = r_result;
        w_dbz_fin = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only a divide by zero reaches DONE straight from IDLE
                w_res_fin = is_rem(bus.op) ? bus.a : '1;
                w_dbz_fin = 1'b1;
            end
            ST_MUL:  w_res_fin = is_high(r_op) ? w_prod_adj[2*WIDTH-1:WIDTH] : w_prod_adj[WIDTH-1:0];
            ST_DIV:  w_res_fin = w_div_adj;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Datapath: load at accept, iterate while busy, capture result on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= MDOP_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= bus.op;
                r_cnt    <= CNT_W'(WIDTH);
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_opnd_mag[0]};
                r_mplier <= w_opnd_mag[1];
                r_quo    <= w_opnd_mag[0];
                r_rem    <= '0;
                r_dvsr   <= w_opnd_mag[1];
                r_neg_q  <= w_opnd_neg[0] ^ w_opnd_neg[1];
                r_neg_r  <= w_opnd_neg[0];
            end else if (r_state == ST_MUL) begin
                r_acc    <= w_acc_step;
                r_mcand  <= r_mcand << 1;
                r_mplier <= w_mplier_step;
                r_cnt    <= r_cnt - CNT_W'(1);
            end else if (r_state == ST_DIV) begin
                r_quo    <= w_quo_step;
                r_rem    <= w_rem_step;
                r_cnt    <= r_cnt - CNT_W'(1);
            end
            if (w_state_next == ST_DONE) begin
                r_result <= w_res_fin;
                r_dbz    <= w_dbz_fin;
            end
        end
    end

    assign w_done          = (r_state == ST_DONE);
    assign bus.done        = w_done;
    assign bus.stall       = bus.start & ~w_done & ~rst;
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_lc3x_muldiv_unit.sv
// Self-checking bench for lc3x_muldiv_unit (WIDTH=16): directed vector table,
// hand-written kill/reset sequences and random ops against an arithmetic model.
module tb_lc3x_muldiv_unit;
    import lc3x_muldiv_types::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    lc3x_muldiv_unit_if #(.WIDTH(16)) bus ();

    lc3x_muldiv_unit #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        lc3x_mdop_t  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic        exp_dbz;
        int          exp_cyc;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic reference straight from the operation definitions
    function automatic void ref_model(input lc3x_mdop_t op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] res, output logic dbz);
        int     sa, sb;
        longint pu, ps;
        sa  = $signed(a);
        sb  = $signed(b);
        pu  = longint'({16'h0, a}) * longint'({16'h0, b});
        ps  = longint'(sa) * longint'(sb);
        dbz = 1'b0;
        res = 16'h0;
        case (op)
            MDOP_MULHU: res = 16'(pu >> 16);
            MDOP_MULHS: res = 16'(ps >>> 16);
            MDOP_DIVU:  if (b == 0) begin res = 16'hFFFF; dbz = 1'b1; end else res = a / b;
            MDOP_REMU:  if (b == 0) begin res = a;        dbz = 1'b1; end else res = a % b;
            MDOP_DIVS:  if (b == 0) begin res = 16'hFFFF; dbz = 1'b1; end else res = 16'(sa / sb);
            MDOP_REMS:  if (b == 0) begin res = a;        dbz = 1'b1; end else res = 16'(sa % sb);
            default:    res = 16'(pu);
        endcase
    endfunction

    function automatic int exp_lat(input lc3x_mdop_t op, input logic [15:0] b);
        logic [15:0] mag;
        int          blen;
        if (op == MDOP_DIVU || op == MDOP_DIVS || op == MDOP_REMU || op == MDOP_REMS)
            return (b == 0) ? 1 : 17;
        mag  = (op == MDOP_MULHS && b[15]) ? (16'h0 - b) : b;
        blen = 0;
        for (int i = 0; i < 16; i++) if (mag[i]) blen = i + 1;
`ifdef LC3X_MULDIV_EARLY_OUT_EN
        return 1 + ((blen < 1) ? 1 : blen);
`else
        return 17 + 0 * blen;
`endif
    endfunction

    // Issue one op starting now (just after an edge). Holds start until done,
    // scrambles operands after accept, optionally kills in cycle kill_at.
    task automatic do_op(input lc3x_mdop_t op, input logic [15:0] a, input logic [15:0] b,
                         input int kill_at, output logic [15:0] res, output logic dbz,
                         output int done_cyc, output logic stall_ok);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        bus.kill  = 1'b0;
        done_cyc  = -1;
        stall_ok  = 1'b1;
        res       = 16'hx;
        dbz       = 1'bx;
        for (int c = 0; c < 60; c++) begin
            if (c == kill_at) bus.kill = 1'b1;
            @(negedge clk);
            if (bus.done) begin
                done_cyc = c;
                res      = bus.result;
                dbz      = bus.div_by_zero;
                if (bus.stall !== 1'b0) stall_ok = 1'b0;
            end else if (bus.stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            bus.a  = 16'($urandom);
            bus.b  = 16'($urandom);
            bus.op = lc3x_mdop_t'($urandom_range(0, 7));
            if (done_cyc >= 0 || c == kill_at) break;
        end
        bus.start = 1'b0;
        bus.kill  = 1'b0;
    endtask

    initial begin
        logic [15:0] res, eres, prev;
        logic        dbz, edbz, sok;
        int          cyc;
        lc3x_mdop_t  rop;
        logic [15:0] ra, rb;

        total = 0;
        bad   = 0;

        tbl[0]  = '{MDOP_MUL,   16'h0007, 16'hFFFD, 16'hFFEB, 1'b0, 17};
        tbl[1]  = '{MDOP_DIVS,  16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 17};
        tbl[2]  = '{MDOP_REMS,  16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 17};
        tbl[3]  = '{MDOP_DIVU,  16'hFFF9, 16'h0002, 16'h7FFC, 1'b0, 17};
        tbl[4]  = '{MDOP_DIVU,  16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1};
        tbl[5]  = '{MDOP_REMU,  16'h1234, 16'h0000, 16'h1234, 1'b1, 1};
        tbl[6]  = '{MDOP_MUL,   16'h0002, 16'h8003, 16'h0006, 1'b0, 17};
        tbl[7]  = '{MDOP_DIVS,  16'h8000, 16'hFFFF, 16'h8000, 1'b0, 17};
        tbl[8]  = '{MDOP_REMS,  16'h8000, 16'hFFFF, 16'h0000, 1'b0, 17};
        tbl[9]  = '{MDOP_MULHS, 16'h8000, 16'h8000, 16'h4000, 1'b0, 17};
        tbl[10] = '{MDOP_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 17};
        tbl[11] = '{MDOP_DIVS,  16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1};
        tbl[12] = '{MDOP_REMS,  16'h8001, 16'h0000, 16'h8001, 1'b1, 1};
        tbl[13] = '{MDOP_RSVD,  16'h0003, 16'h8005, 16'h800F, 1'b0, 17};

        // Reset: stall suppressed while rst high even with start requested
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.kill  = 1'b0;
        bus.op    = MDOP_MUL;
        bus.a     = 16'h0003;
        bus.b     = 16'h0003;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        chk("rst_result", 32'(bus.result), 32'h0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, -1, res, dbz, cyc, sok);
            $display("vec %0d op=%s a=%h b=%h result=%h dbz=%0b done_cycle=%0d",
                     i, tbl[i].op.name(), tbl[i].a, tbl[i].b, res, dbz, cyc);
            chk($sformatf("vec%0d_result", i), 32'(res), 32'(tbl[i].exp_res));
            chk($sformatf("vec%0d_dbz", i), 32'(dbz), 32'(tbl[i].exp_dbz));
            chk($sformatf("vec%0d_cycle", i), 32'(cyc), 32'(tbl[i].exp_cyc));
            chk($sformatf("vec%0d_stall", i), 32'(sok), 32'd1);
        end

        // Multiply latency, fixed or early-out
        do_op(MDOP_MUL, 16'h0005, 16'h0001, -1, res, dbz, cyc, sok);
        $display("eo1 op=MUL a=0005 b=0001 result=%h done_cycle=%0d", res, cyc);
        chk("eo1_result", 32'(res), 32'h5);
`ifdef LC3X_MULDIV_EARLY_OUT_EN
        chk("eo1_cycle", 32'(cyc), 32'd2);
`else
        chk("eo1_cycle", 32'(cyc), 32'd17);
`endif
        do_op(MDOP_MUL, 16'h0005, 16'h00FF, -1, res, dbz, cyc, sok);
        $display("eo2 op=MUL a=0005 b=00ff result=%h done_cycle=%0d", res, cyc);
        chk("eo2_result", 32'(res), 32'h04FB);
`ifdef LC3X_MULDIV_EARLY_OUT_EN
        chk("eo2_cycle", 32'(cyc), 32'd9);
`else
        chk("eo2_cycle", 32'(cyc), 32'd17);
`endif
        chk("eo2_stall", 32'(sok), 32'd1);
        prev = res;

        // Kill in cycle 5 of a divide: no done, idle next cycle, result held
        do_op(MDOP_DIVU, 16'd100, 16'd7, 5, res, dbz, cyc, sok);
        $display("kill op=DIVU a=0064 b=0007 done_cycle=%0d", cyc);
        chk("kill_no_done", 32'(cyc), 32'hFFFF_FFFF);
        #2;
        chk("kill_idle_done", 32'(bus.done), 32'd0);
        chk("kill_result_held", 32'(bus.result), 32'(prev));
        chk("kill_idle_stall", 32'(bus.stall), 32'd0);
        do_op(MDOP_MUL, 16'd3, 16'd4, -1, res, dbz, cyc, sok);
        $display("post_kill op=MUL a=0003 b=0004 result=%h done_cycle=%0d", res, cyc);
        chk("post_kill_result", 32'(res), 32'h000C);
        chk("post_kill_cycle", 32'(cyc), 32'(exp_lat(MDOP_MUL, 16'd4)));

        // Reset in the middle of a divide
        bus.op    = MDOP_DIVU;
        bus.a     = 16'd100;
        bus.b     = 16'd7;
        bus.start = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        $display("midrst result=%h done=%0b dbz=%0b", bus.result, bus.done, bus.div_by_zero);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_result", 32'(bus.result), 32'h0);
        @(posedge clk);
        #1;

        // Random ops against the reference model
        for (int n = 0; n < 40; n++) begin
            rop = lc3x_mdop_t'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 16'h0;
                1: begin ra = 16'h8000; rb = 16'hFFFF; end
                2: rb = 16'($urandom_range(0, 255));
                default: ;
            endcase
            ref_model(rop, ra, rb, eres, edbz);
            do_op(rop, ra, rb, -1, res, dbz, cyc, sok);
            $display("rnd %0d op=%s a=%h b=%h result=%h dbz=%0b done_cycle=%0d",
                     n, rop.name(), ra, rb, res, dbz, cyc);
            chk($sformatf("rnd%0d_result", n), 32'(res), 32'(eres));
            chk($sformatf("rnd%0d_dbz", n), 32'(dbz), 32'(edbz));
            chk($sformatf("rnd%0d_cycle", n), 32'(cyc), 32'(exp_lat(rop, rb)));
            chk($sformatf("rnd%0d_stall", n), 32'(sok), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
